maxnet_update_unit: RTL and testbench

- Upstream compute stage for one MaxNet neuron. Produces the next activation value and its load strobe for that neuron's 32-bit activation register (ports newDataIn and ldA).
- Reads all N activation registers serially, one per cycle, via an index mux. It then computes a_self − EPS·Σ(a_k, k≠self), applies ReLU with saturation, and pulses ldA.
- Also flags convergence: all other activations are zero.

---
 rtl/maxnet_pkg.sv | 28 ++
 rtl/maxnet_update_unit_if.sv | 30 +++
 rtl/relu_sat32.sv | 24 ++
 rtl/maxnet_update_unit.sv | 111 +++++++++++
 tb/tb_maxnet_update_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the MaxNet neuron update unit.
//   N           number of neurons / activation registers
//   IDXW        activation index width (2**IDXW >= N)
//   FRAC        fractional bits of the Q16.16 activation format
//   EPS_DEFAULT default inhibition weight, unsigned Q16.16 (~0.2)
//   ACT_MAX     largest representable positive activation
package maxnet_pkg;

   localparam int unsigned N    = 4;
   localparam int unsigned IDXW = 2;
   localparam int unsigned FRAC = 16;

   localparam logic [31:0] EPS_DEFAULT = 32'h0000_3333;
   localparam logic [31:0] ACT_MAX     = 32'h7FFF_FFFF;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACC   = 2'd1;
   localparam logic [1:0] ST_SCALE = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ACC   = ST_ACC,
      SCALE = ST_SCALE,
      OUT   = ST_OUT
   } state_t;

endpackage

// File: rtl/maxnet_update_unit_if.sv
// Request / activation-read / result bundle of the MaxNet update unit.
//   start, selfIdx       update request and neuron index
//   actIdx, actIn        serial read port into the activation register file
//   newData, ldA, done   result and its load strobe
//   busy, othersZero     status
// slave is the update unit's view, master the surrounding datapath's view.
interface maxnet_update_unit_if;
   import maxnet_pkg::*;

   logic            start;
   logic [IDXW-1:0] selfIdx;
   logic [IDXW-1:0] actIdx;
   logic [31:0]     actIn;
   logic [31:0]     newData;
   logic            ldA;
   logic            done;
   logic            busy;
   logic            othersZero;

   modport slave (
      input  start, selfIdx, actIn,
      output actIdx, newData, ldA, done, busy, othersZero
   );

   modport master (
      output start, selfIdx, actIn,
      input  actIdx, newData, ldA, done, busy, othersZero
   );

endinterface

// File: rtl/relu_sat32.sv
// Combinational ReLU with saturation: clamps a wide signed value to [0, ACT_MAX].
//   din       signed input of width W
//   satOut_c  32-bit clamped result
module relu_sat32
   import maxnet_pkg::*;
#(
   parameter int unsigned W = 69
) (
   input  logic signed [W-1:0] din,
   output logic        [31:0]  satOut_c
);

   localparam logic signed [W-1:0] MAX_W = W'(ACT_MAX);

   always_comb begin
      satOut_c = din[31:0];
      if (din[W-1]) begin
         satOut_c = '0;
      end else if (din > MAX_W) begin
         satOut_c = ACT_MAX;
      end
   end

endmodule

// File: rtl/maxnet_update_unit.sv
// Update stage for one MaxNet neuron: serially reads all activations, computes
// relu_sat(a_self - EPS * sum(a_k, k != self)) and strobes it out with ldA.
//   clk, rst   clock, asynchronous active-high reset
//   bus        maxnet_update_unit_if.slave (request, activation read port, result, status)
module maxnet_update_unit
   import maxnet_pkg::*;
#(
   parameter logic [31:0] EPS = EPS_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   maxnet_update_unit_if.slave         bus
);

   localparam int unsigned SUMW  = 32 + IDXW + 1;
   localparam int unsigned PRODW = SUMW + 33;
   localparam int unsigned DIFFW = PRODW + 1;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   state_t                  state;
   logic [IDXW-1:0]         selfIdxQ;
   logic signed [31:0]      aSelf;
   logic signed [SUMW-1:0]  sumOthers;
   logic                    zeroFlag;

   logic signed [PRODW-1:0] sumExt;
   logic signed [PRODW-1:0] epsExt;
   logic signed [PRODW-1:0] prod;
   logic signed [PRODW-1:0] scaled;
   logic signed [DIFFW-1:0] diff;
   logic [31:0]             satData_c;

   // Scaling and difference are evaluated during SCALE and captured on the edge into OUT.
   always_comb begin
      sumExt = PRODW'(sumOthers);
      epsExt = PRODW'(EPS);
      prod   = sumExt * epsExt;
      scaled = prod >>> FRAC;
      diff   = DIFFW'(aSelf) - DIFFW'(scaled);
   end

   relu_sat32 #(.W(DIFFW)) uSat (
      .din      (diff),
      .satOut_c (satData_c)
   );

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         selfIdxQ       <= '0;
         aSelf          <= '0;
         sumOthers      <= '0;
         zeroFlag       <= 1'b0;
         bus.actIdx     <= '0;
         bus.newData    <= '0;
         bus.ldA        <= 1'b0;
         bus.done       <= 1'b0;
         bus.busy       <= 1'b0;
         bus.othersZero <= 1'b0;
      end else begin
         bus.ldA  <= 1'b0;
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               bus.actIdx <= '0;
               if (bus.start) begin
                  selfIdxQ  <= bus.selfIdx;
                  aSelf     <= '0;
                  sumOthers <= '0;
                  zeroFlag  <= 1'b1;
                  bus.busy  <= 1'b1;
                  state     <= ACC;
               end
            end
            ACC: begin
               if (bus.actIdx == selfIdxQ) begin
                  aSelf <= $signed(bus.actIn);
               end else begin
                  sumOthers <= sumOthers + SUMW'($signed(bus.actIn));
                  if (bus.actIn != '0) begin
                     zeroFlag <= 1'b0;
                  end
               end
               if (bus.actIdx == LAST_IDX) begin
                  bus.actIdx <= '0;
                  state      <= SCALE;
               end else begin
                  bus.actIdx <= bus.actIdx + IDXW'(1);
               end
            end
            SCALE: begin
               bus.newData    <= satData_c;
               bus.ldA        <= 1'b1;
               bus.done       <= 1'b1;
               bus.othersZero <= zeroFlag;
               state          <= OUT;
            end
            OUT: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maxnet_update_unit.sv
// Scoreboard bench for maxnet_update_unit: stimulus pushes hand-computed
// results, a monitor pops and compares whenever ldA is presented.
module tb_maxnet_update_unit;
   import maxnet_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        zero;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] acts [N];
   exp_t        expQ [$];
   int          checks   = 0;
   int          errors   = 0;
   int          cycleCnt = 0;
   int          ldaTotal = 0;

   maxnet_update_unit_if bus ();

   maxnet_update_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   assign bus.actIn = acts[bus.actIdx];

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every ldA must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.ldA) begin
         ldaTotal++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpectedLdA: got ldA=1 with newData=0x%08h, expected no ldA (t=%0t)",
                     bus.newData, $time);
         end else begin
            e = expQ.pop_front();
            chk("newData", bus.newData, e.data);
            chk("othersZero", 32'(bus.othersZero), 32'(e.zero));
            chk("doneWithLdA", 32'(bus.done), 32'd1);
            chk("latency", 32'(cycleCnt), 32'(e.cyc));
         end
      end
   end

   task automatic setActs(input logic [31:0] a0, a1, a2, a3);
      acts[0] = a0; acts[1] = a1; acts[2] = a2; acts[3] = a3;
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first ACC cycle.
   task automatic issue(input logic [IDXW-1:0] sel, input logic [31:0] expData, input logic expZero);
      exp_t e;
      bus.start   = 1'b1;
      bus.selfIdx = sel;
      @(negedge clk);
      bus.start = 1'b0;
      e.data = expData;
      e.zero = expZero;
      e.cyc  = cycleCnt + int'(N) + 1;
      expQ.push_back(e);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 40; i++) begin
         if (expQ.size() == 0) break;
         @(negedge clk);
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d outstanding results, expected 0", expQ.size());
         expQ.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      int base;
      bus.start   = 1'b0;
      bus.selfIdx = '0;
      setActs(32'h0, 32'h0, 32'h0, 32'h0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rstActIdx", 32'(bus.actIdx), 32'd0);
      chk("rstNewData", bus.newData, 32'd0);
      chk("rstLdA", 32'(bus.ldA), 32'd0);
      chk("rstDone", 32'(bus.done), 32'd0);
      chk("rstBusy", 32'(bus.busy), 32'd0);
      chk("rstOthersZero", 32'(bus.othersZero), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: nominal update, with busy window
      setActs(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0);
      chk("busyIdle", 32'(bus.busy), 32'd0);
      issue(2'd0, 32'h0000_D99A, 1'b0);
      for (int p = 1; p <= 6; p++) begin
         chk($sformatf("busyCycle%0d", p), 32'(bus.busy), 32'd1);
         @(negedge clk);
      end
      chk("busyAfter", 32'(bus.busy), 32'd0);
      waitIdle();
      chk("newDataHold", bus.newData, 32'h0000_D99A);

      // 2: clamp to zero
      issue(2'd3, 32'h0, 1'b0);
      waitIdle();

      // 3: convergence, then a single nonzero LSB among the others
      setActs(32'h0002_0000, 32'h0, 32'h0, 32'h0);
      issue(2'd0, 32'h0002_0000, 1'b1);
      waitIdle();
      chk("othersZeroHold", 32'(bus.othersZero), 32'd1);
      setActs(32'h0002_0000, 32'h1, 32'h0, 32'h0);
      issue(2'd0, 32'h0002_0000, 1'b0);
      waitIdle();

      // 4: positive saturation
      setActs(32'h7FFF_FFFF, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000);
      issue(2'd0, 32'h7FFF_FFFF, 1'b0);
      waitIdle();

      // 5: reset during ACC aborts the update
      setActs(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0);
      issue(2'd0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      expQ.delete();
      chk("abortBusy", 32'(bus.busy), 32'd0);
      chk("abortNewData", bus.newData, 32'd0);
      chk("abortLdA", 32'(bus.ldA), 32'd0);
      chk("abortActIdx", 32'(bus.actIdx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.ldA) n++;
      end
      chk("noLdaAfterRst", 32'(n), 32'd0);
      issue(2'd0, 32'h0000_D99A, 1'b0);
      waitIdle();

      // 6: starts while busy and coincident with done are dropped
      base = ldaTotal;
      issue(2'd0, 32'h0000_D99A, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("doneSeen", 32'(bus.done), 32'd1);
      bus.start = 1'b1;
      @(negedge clk);
      issue(2'd0, 32'h0000_D99A, 1'b0);
      waitIdle();
      repeat (10) @(negedge clk);
      chk("ldaCountBusyStarts", 32'(ldaTotal - base), 32'd2);
      chk("queueEmpty", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
